// File: rtl/rem_pkg.sv
// Shared widths and operand layout for the sign-magnitude remainder unit.
package rem_pkg;

  localparam int unsigned MAG_W    = 2;
  localparam int unsigned OUT_W    = 5;
  localparam int unsigned SIGN_IN  = MAG_W;
  localparam int unsigned SIGN_OUT = OUT_W - 1;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } operand_t;

endpackage

// File: rtl/rem_core.sv
// Combinational unsigned restoring division; only the remainder is kept.
module rem_core #(
  parameter int unsigned MAG_W = 2
) (
  input  logic [MAG_W-1:0] mag_n,
  input  logic [MAG_W-1:0] mag_d,
  output logic [MAG_W-1:0] mag_r,
  output logic             dz
);

  logic [MAG_W:0]   part;
  logic [MAG_W-1:0] num_sh;
  logic             unused_part_msb;

  // Shift numerator bits into the partial remainder MSB-first, subtracting the
  // divisor whenever it fits; a zero divisor leaves the numerator untouched.
  always_comb begin
    part   = '0;
    num_sh = mag_n;
    for (int unsigned i = 0; i < MAG_W; i++) begin
      part   = {part[MAG_W-1:0], num_sh[MAG_W-1]};
      num_sh = num_sh << 1;
      if (part >= {1'b0, mag_d}) begin
        part = part - {1'b0, mag_d};
      end
    end
  end

  // The final partial remainder is below the divisor, so its MSB is always 0.
  assign mag_r           = part[MAG_W-1:0];
  assign unused_part_msb = part[MAG_W];
  assign dz              = (mag_d == '0);

endmodule

// File: rtl/rem.sv
// Registered sign-magnitude remainder: sign follows the numerator, flags zero
// remainder and divide-by-zero, one-cycle latency.
module rem
  import rem_pkg::*;
#(
  parameter int unsigned MAG_W = rem_pkg::MAG_W,
  parameter int unsigned OUT_W = rem_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W:0]   numerator,
  input  logic [MAG_W:0]   denominator,
  output logic [OUT_W-1:0] remainder,
  output logic             zero,
  output logic             divbyzero
);

  logic [MAG_W-1:0] mag_r;
  logic             dz;
  logic [OUT_W-1:0] rem_d;
  logic             zero_d;
  logic             dbz_d;
  logic             unused_den_sign;

  // The denominator sign has no effect on a truncating remainder.
  assign unused_den_sign = denominator[MAG_W];

  rem_core #(
    .MAG_W(MAG_W)
  ) u_core (
    .mag_n(numerator[MAG_W-1:0]),
    .mag_d(denominator[MAG_W-1:0]),
    .mag_r(mag_r),
    .dz   (dz)
  );

  // Assemble the next result word and flags; a zero divisor keeps only the sign.
  always_comb begin
    rem_d              = '0;
    rem_d[OUT_W-1]     = numerator[MAG_W];
    zero_d             = 1'b0;
    dbz_d              = dz;
    if (!dz) begin
      rem_d[MAG_W-1:0] = mag_r;
      zero_d           = (mag_r == '0);
    end
  end

  // Output register bank, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remainder <= '0;
      zero      <= 1'b0;
      divbyzero <= 1'b0;
    end else begin
      remainder <= rem_d;
      zero      <= zero_d;
      divbyzero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_rem.sv
// Scoreboard bench for rem: expected results are queued at drive time and
// compared one cycle later when the registered outputs appear.
module tb_rem;
  import rem_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] numerator;
  logic [2:0] denominator;
  logic [4:0] remainder;
  logic       zero;
  logic       divbyzero;

  typedef struct {
    string      tag;
    logic [4:0] r;
    logic       z;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  rem #(
    .MAG_W(2),
    .OUT_W(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .numerator  (numerator),
    .denominator(denominator),
    .remainder  (remainder),
    .zero       (zero),
    .divbyzero  (divbyzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [2:0] n, input logic [2:0] d);
    exp_t e;
    logic [1:0] nm;
    logic [1:0] dm;
    logic [1:0] rm;
    nm    = n[1:0];
    dm    = d[1:0];
    e.tag = tag;
    if (dm == 2'd0) begin
      e.r = {n[2], 4'b0000};
      e.z = 1'b0;
      e.d = 1'b1;
    end else begin
      rm  = nm % dm;
      e.r = {n[2], 2'b00, rm};
      e.z = (rm == 2'd0);
      e.d = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, ".rem"}, {3'b000, remainder}, {3'b000, e.r});
    check({e.tag, ".zero"}, {7'b0, zero}, {7'b0, e.z});
    check({e.tag, ".dbz"}, {7'b0, divbyzero}, {7'b0, e.d});
  endtask

  // At each falling edge: score the result of the previous operation, then
  // drive the next one and queue its expectation.
  task automatic step(input string tag, input logic [2:0] n, input logic [2:0] d);
    @(negedge clk);
    compare_head();
    numerator   = n;
    denominator = d;
    sb.push_back(model(tag, n, d));
  endtask

  task automatic drain();
    @(negedge clk);
    compare_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    operand_t nop;
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    numerator   = 3'b011;
    denominator = 3'b010;
    #2;
    check("reset.rem", {3'b000, remainder}, 8'd0);
    check("reset.zero", {7'b0, zero}, 8'd0);
    check("reset.dbz", {7'b0, divbyzero}, 8'd0);

    @(negedge clk);
    rst = 1'b0;

    step("pos", 3'b011, 3'b010);
    step("negnum", 3'b111, 3'b110);
    step("exact", 3'b010, 3'b001);
    step("exactneg", 3'b110, 3'b010);
    step("negzero", 3'b100, 3'b001);
    step("dz_neg", 3'b101, 3'b100);
    step("dz_pos", 3'b001, 3'b000);
    drain();

    // Reset in the middle of operation clears outputs without a clock edge.
    step("prerst", 3'b011, 3'b010);
    @(posedge clk);
    #1;
    compare_head();
    rst = 1'b1;
    #1;
    check("midrst.rem", {3'b000, remainder}, 8'd0);
    check("midrst.zero", {7'b0, zero}, 8'd0);
    check("midrst.dbz", {7'b0, divbyzero}, 8'd0);
    @(negedge clk);
    check("holdrst.rem", {3'b000, remainder}, 8'd0);
    rst = 1'b0;
    sb.push_back(model("postrst", numerator, denominator));
    drain();

    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        nop.sign = n[2];
        nop.mag  = n[1:0];
        step($sformatf("ex_n%0d_d%0d", n, d), nop, d[2:0]);
      end
    end
    drain();

    check("sb_empty", sb.size() == 0 ? 8'd1 : 8'd0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
